// File: rtl/rr_priority_arbiter.sv
// N-way arbiter, fixed-priority or round-robin: the registered one-hot grant appears one cycle after req is sampled.
// The grant is held until ack, until the holder drops req, or until the optional hold timeout; at least one idle cycle follows every release.
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N-1:0]                         req,
    input  logic                                 ack,
    output logic [N-1:0]                         gnt,
    output logic                                 gnt_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
    output logic                                 timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] TOP_IDX   = IW'(N - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q;
    logic [N-1:0]   gnt_q;
    logic           gnt_valid_q;
    logic [IW-1:0]  gnt_idx_q;
    logic           timeout_q;
    logic [IW-1:0]  ptr_q;
    logic [HW-1:0]  hold_q;

    logic [IW-1:0]  base;
    logic           win_vld;
    logic [IW-1:0]  win_idx;
    int             pos;
    logic [IW-1:0]  pos_idx;
    logic           hold_exp;
    logic           rel_normal;

    // Descending search with wrap from base; fixed mode always starts at the top index.
    always_comb begin
        base    = (RR_MODE != 0) ? ptr_q : TOP_IDX;
        win_vld = 1'b0;
        win_idx = '0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(base) - i;
            if (pos < 0) begin
                pos = pos + N;
            end
            pos_idx = IW'(pos);
            if (!win_vld && req[pos_idx]) begin
                win_vld = 1'b1;
                win_idx = pos_idx;
            end
        end
    end

    assign hold_exp   = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);
    assign rel_normal = ack || !req[gnt_idx_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            timeout_q   <= 1'b0;
            ptr_q       <= TOP_IDX;
            hold_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q     <= GRANT;
                        gnt_q       <= ONE << win_idx;
                        gnt_valid_q <= 1'b1;
                        gnt_idx_q   <= win_idx;
                        hold_q      <= '0;
                    end
                end
                GRANT: begin
                    if (rel_normal || hold_exp) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        gnt_idx_q   <= '0;
                        // A coinciding ack or abandon makes the release a normal one.
                        timeout_q   <= hold_exp && !rel_normal;
                        if (RR_MODE != 0) begin
                            ptr_q <= (gnt_idx_q == '0) ? TOP_IDX : gnt_idx_q - 1'b1;
                        end
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: three arbiter configurations (fixed, round-robin, fixed with MAX_HOLD=4) driven one at a time.
module tb_rr_priority_arbiter;

    typedef struct {
        int         unit;
        int         start;
        logic [7:0] g;
        logic [2:0] idx;
        int         len;
    } exp_t;

    typedef struct {
        int unit;
        int at;
    } to_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_w [3];
    logic       ack_w [3];
    logic [7:0] gnt_w [3];
    logic       gv_w  [3];
    logic [2:0] idx_w [3];
    logic       to_w  [3];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    exp_t exp_q[$];
    to_t  to_q[$];
    exp_t e;
    to_t  te;

    bit         prev_gv [3];
    int         held    [3];
    int         cur_len [3];
    logic [7:0] cap     [3];

    rr_priority_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .reset(reset), .req(req_w[0]), .ack(ack_w[0]),
        .gnt(gnt_w[0]), .gnt_valid(gv_w[0]), .gnt_idx(idx_w[0]), .timeout(to_w[0]));

    rr_priority_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset(reset), .req(req_w[1]), .ack(ack_w[1]),
        .gnt(gnt_w[1]), .gnt_valid(gv_w[1]), .gnt_idx(idx_w[1]), .timeout(to_w[1]));

    rr_priority_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(4)) u_to (
        .clk(clk), .reset(reset), .req(req_w[2]), .ack(ack_w[2]),
        .gnt(gnt_w[2]), .gnt_valid(gv_w[2]), .gnt_idx(idx_w[2]), .timeout(to_w[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grant starts, hold lengths, stability and timeout pulses checked against queued expectations.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            compared++;
            if (gv_w[u] !== (|gnt_w[u]) || !$onehot0(gnt_w[u]) ||
                (gv_w[u] ? (gnt_w[u] !== (8'd1 << idx_w[u])) : (idx_w[u] !== 3'd0))) begin
                mismatched++;
                $display("FAIL invariant unit%0d cyc%0d: gnt=%b valid=%b idx=%0d", u, cyc, gnt_w[u], gv_w[u], idx_w[u]);
            end
            if (gv_w[u] === 1'b1 && !prev_gv[u]) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    cur_len[u] = -1;
                    $display("FAIL unexpected_grant unit%0d cyc%0d: gnt=%b, required none", u, cyc, gnt_w[u]);
                end else begin
                    e = exp_q.pop_front();
                    cur_len[u] = e.len;
                    if (e.unit != u || e.start != cyc || e.g !== gnt_w[u] || e.idx !== idx_w[u]) begin
                        mismatched++;
                        $display("FAIL grant_start unit%0d cyc%0d gnt=%b idx=%0d, required unit%0d cyc%0d gnt=%b idx=%0d",
                                 u, cyc, gnt_w[u], idx_w[u], e.unit, e.start, e.g, e.idx);
                    end
                end
                held[u] = 1;
                cap[u]  = gnt_w[u];
            end else if (gv_w[u] === 1'b1 && prev_gv[u]) begin
                held[u]++;
                compared++;
                if (gnt_w[u] !== cap[u]) begin
                    mismatched++;
                    $display("FAIL grant_stable unit%0d cyc%0d: gnt=%b, required %b", u, cyc, gnt_w[u], cap[u]);
                end
            end else if (prev_gv[u]) begin
                compared++;
                if (held[u] != cur_len[u]) begin
                    mismatched++;
                    $display("FAIL hold_len unit%0d cyc%0d: held %0d cycles, required %0d", u, cyc, held[u], cur_len[u]);
                end
            end
            if (to_w[u] === 1'b1) begin
                compared++;
                if (to_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_timeout unit%0d cyc%0d: timeout=1, required 0", u, cyc);
                end else begin
                    te = to_q.pop_front();
                    if (te.unit != u || te.at != cyc || gv_w[u] !== 1'b0) begin
                        mismatched++;
                        $display("FAIL timeout unit%0d cyc%0d valid=%b, required unit%0d cyc%0d valid=0",
                                 u, cyc, gv_w[u], te.unit, te.at);
                    end
                end
            end
            prev_gv[u] = (gv_w[u] === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name, input int u);
        compared++;
        if (gnt_w[u] !== 8'd0 || gv_w[u] !== 1'b0 || idx_w[u] !== 3'd0 || to_w[u] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s unit%0d: gnt=%b valid=%b idx=%0d timeout=%b, required all zero",
                     name, u, gnt_w[u], gv_w[u], idx_w[u], to_w[u]);
        end
    endtask

    // Caller has req set with the arbiter idle; the grant shows next cycle, is held len cycles, then acked.
    task automatic grant_cycle(input int u, input logic [7:0] g, input logic [2:0] idx, input int len);
        exp_q.push_back('{unit: u, start: cyc + 1, g: g, idx: idx, len: len});
        tick(len);
        ack_w[u] = 1'b1;
        tick(1);
        ack_w[u] = 1'b0;
    endtask

    initial begin
        int         order [9];
        logic [7:0] g;
        order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            req_w[u] = 8'h00;
            ack_w[u] = 1'b0;
        end
        tick(3);
        reset = 1'b0;
        for (int u = 0; u < 3; u++) chk_idle("reset_state", u);

        // Fixed priority: highest set index wins, regrant after one idle cycle.
        req_w[0] = 8'b1010_0100;
        grant_cycle(0, 8'h80, 3'd7, 2);
        grant_cycle(0, 8'h80, 3'd7, 1);
        req_w[0] = 8'b0000_0101;
        grant_cycle(0, 8'h04, 3'd2, 3);
        req_w[0] = 8'h00;
        tick(2);

        // Round-robin full rotation with all requesters active.
        req_w[1] = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            g = 8'd1 << order[k];
            grant_cycle(1, g, 3'(order[k]), 1 + (k % 2));
        end
        req_w[1] = 8'h00;
        tick(2);

        // Wrap-around: idx1, idx0 (pointer wraps to 7), idx1 again.
        req_w[1] = 8'b0000_0011;
        grant_cycle(1, 8'h02, 3'd1, 1);
        grant_cycle(1, 8'h01, 3'd0, 2);
        grant_cycle(1, 8'h02, 3'd1, 1);
        req_w[1] = 8'h00;
        tick(2);

        // Holder abandons; other requests raised mid-grant change nothing; pointer moves past idx4.
        req_w[1] = 8'h10;
        exp_q.push_back('{unit: 1, start: cyc + 1, g: 8'h10, idx: 3'd4, len: 3});
        tick(1);
        req_w[1] = 8'hFF;
        tick(2);
        req_w[1] = 8'hEF;
        tick(1);
        grant_cycle(1, 8'h08, 3'd3, 2);
        req_w[1] = 8'h00;
        tick(2);

        // Reset during a grant, then the first grant follows the top-down order again.
        req_w[1] = 8'hFF;
        exp_q.push_back('{unit: 1, start: cyc + 1, g: 8'h04, idx: 3'd2, len: 2});
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_idle("reset_mid_grant", 1);
        grant_cycle(1, 8'h80, 3'd7, 1);
        req_w[1] = 8'h00;
        tick(2);

        // Hold timeout after 4 cycles, then ack on the 4th cycle suppresses the pulse.
        req_w[2] = 8'h08;
        exp_q.push_back('{unit: 2, start: cyc + 1, g: 8'h08, idx: 3'd3, len: 4});
        to_q.push_back('{unit: 2, at: cyc + 5});
        tick(5);
        grant_cycle(2, 8'h08, 3'd3, 4);
        req_w[2] = 8'h00;
        tick(4);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_grants: %0d expected grants never seen, required 0", exp_q.size());
        end
        compared++;
        if (to_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_timeouts: %0d expected pulses never seen, required 0", to_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
